// File: rtl/ge_reg_machine_if.sv
// Handshake and data bundle between the fitness harness (master) and the
// register-program interpreter (slave).
interface ge_reg_machine_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int DEPTH = 16
);
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(2 * NREG);
  localparam int IW = 3 + RW + SW;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic                  prog_we;
  logic [AW-1:0]         prog_addr;
  logic [IW-1:0]         prog_wdata;
  logic [LW-1:0]         prog_len;
  logic                  start;
  logic [NREG*WIDTH-1:0] in_data;
  logic                  busy;
  logic                  done;
  logic [NREG*WIDTH-1:0] out_data;

  modport master (
    output prog_we, prog_addr, prog_wdata, prog_len, start, in_data,
    input  busy, done, out_data
  );

  modport slave (
    input  prog_we, prog_addr, prog_wdata, prog_len, start, in_data,
    output busy, done, out_data
  );
endinterface

// File: rtl/ge_reg_machine.sv
// Sequential interpreter for straight-line register programs: one instruction
// per clock over NREG registers, with a start/busy/done handshake.
module ge_reg_machine #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  ge_reg_machine_if.slave  bus
);
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(2 * NREG);
  localparam int IW = 3 + RW + SW;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_MOV  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_LNOT = 3'd4;
  localparam logic [2:0] OP_BNOT = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] d,
                                           input logic [WIDTH-1:0] s);
    case (op)
      OP_MOV:  alu = s;
      OP_AND:  alu = d & s;
      OP_OR:   alu = d | s;
      OP_XOR:  alu = d ^ s;
      OP_LNOT: alu = {{(WIDTH-1){1'b0}}, (s == '0)};
      OP_BNOT: alu = ~s;
      default: alu = d;
    endcase
  endfunction

  state_t                state, state_n;
  logic [IW-1:0]         mem [DEPTH];
  logic [WIDTH-1:0]      r     [NREG];
  logic [WIDTH-1:0]      r_nxt [NREG];
  logic [WIDTH-1:0]      in_q  [NREG];
  logic [WIDTH-1:0]      in_lane [NREG];
  logic [NREG*WIDTH-1:0] r_nxt_packed;
  logic [AW-1:0]         pc;
  logic [LW-1:0]         len;
  logic [LW-1:0]         len_clamp;
  logic                  done_q;
  logic [NREG*WIDTH-1:0] out_q;

  logic [IW-1:0]         instr;
  logic [2:0]            op;
  logic [RW-1:0]         rd;
  logic [SW-1:0]         src;
  logic [WIDTH-1:0]      s_val;
  logic                  go;
  logic                  last;

  assign instr = mem[pc];
  assign op    = instr[IW-1 -: 3];
  assign rd    = instr[SW +: RW];
  assign src   = instr[SW-1:0];
  // NREG is a power of two, so the src MSB picks input lanes vs registers.
  assign s_val = src[SW-1] ? in_q[src[RW-1:0]] : r[src[RW-1:0]];
  assign go    = (state == IDLE) && bus.start;
  assign last  = (LW'(pc) == len - LW'(1)) || (op == OP_HALT);
  assign len_clamp = (bus.prog_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.prog_len;

  assign bus.busy     = (state == RUN);
  assign bus.done     = done_q;
  assign bus.out_data = out_q;

  always_comb begin
    r_nxt        = r;
    r_nxt[rd]    = alu(op, r[rd], s_val);
    r_nxt_packed = '0;
    in_lane      = in_q;
    for (int i = 0; i < NREG; i++) begin
      r_nxt_packed[i*WIDTH +: WIDTH] = r_nxt[i];
      in_lane[i] = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (go && (len_clamp != '0)) state_n = RUN;
      RUN:     if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Program memory keeps its contents across reset; writes only while idle.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state == IDLE)) mem[bus.prog_addr] <= bus.prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r[i]    <= '0;
        in_q[i] <= '0;
      end
      pc     <= '0;
      len    <= '0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        r    <= in_lane;
        in_q <= in_lane;
        len  <= len_clamp;
        pc   <= '0;
        if (len_clamp == '0) begin
          out_q  <= bus.in_data;
          done_q <= 1'b1;
        end
      end else if (state == RUN) begin
        r  <= r_nxt;
        pc <= pc + AW'(1);
        if (last) begin
          out_q  <= r_nxt_packed;
          done_q <= 1'b1;
        end
      end
    end
  end
endmodule
